// File: rtl/sa_sync_evt_capture_pkg.sv
// Shared encodings for the synchronized-event capture stage: edge select
// codes, status FSM states and the edge qualification rule.
package sa_sync_evt_capture_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_OVF  = 2'b10
    } state_e;

    function automatic logic edge_qualifies(edge_sel_e sel, logic rising);
        case (sel)
            EDGE_RISE: return rising;
            EDGE_FALL: return !rising;
            EDGE_BOTH: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sa_sync_evt_capture_if.sv
// Control/status bundle between the capture stage and its consumer
// (interrupt aggregation, CSRs, or a control FSM).
interface sa_sync_evt_capture_if #(
    parameter int FILT_W = 4,
    parameter int CNT_W  = 8
);
    logic              sync_in;
    logic [FILT_W-1:0] filt_len;
    logic [1:0]        edge_sel;
    logic              ack;
    logic              lvl_out;
    logic              evt_pulse;
    logic              pending;
    logic              overflow;
    logic [CNT_W-1:0]  evt_cnt;

    modport master (
        output sync_in, filt_len, edge_sel, ack,
        input  lvl_out, evt_pulse, pending, overflow, evt_cnt
    );

    modport slave (
        input  sync_in, filt_len, edge_sel, ack,
        output lvl_out, evt_pulse, pending, overflow, evt_cnt
    );
endinterface

// File: rtl/sa_glitch_filter.sv
// Stability filter: a level change commits only after the new value has been
// sampled filt_len+1 consecutive cycles; commit/rising describe that edge.
module sa_glitch_filter #(
    parameter int FILT_W  = 4,
    parameter bit RST_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              clr_,
    input  logic              sync_in,
    input  logic [FILT_W-1:0] filt_len,
    output logic              lvl,
    output logic              commit,
    output logic              rising
);
    logic              lvl_q, lvl_d;
    logic [FILT_W-1:0] run_q, run_d;

    // NOTE: every output of this block gets a default before the ifs, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        lvl_d  = lvl_q;
        run_d  = '0;
        commit = 1'b0;
        if (sync_in != lvl_q) begin
            if (run_q >= filt_len) begin
                lvl_d  = sync_in;
                commit = 1'b1;
            end else begin
                run_d = run_q + FILT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            lvl_q <= RST_LVL;
            run_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            run_q <= run_d;
        end
    end

    assign lvl    = lvl_q;
    assign rising = sync_in;

endmodule

// File: rtl/sa_sync_evt_capture.sv
// Event capture downstream of a 2-flop synchronizer: filtered level, edge
// qualification, pending/overflow status FSM and saturating event counter.
module sa_sync_evt_capture
    import sa_sync_evt_capture_pkg::*;
#(
    parameter int FILT_W  = 4,
    parameter int CNT_W   = 8,
    parameter bit RST_LVL = 1'b0
) (
    input  logic                  clk,
    input  logic                  clr_,
    sa_sync_evt_capture_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             lvl, commit, rising;
    logic             evt_pulse_q, evt_pulse_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sa_glitch_filter #(
        .FILT_W  (FILT_W),
        .RST_LVL (RST_LVL)
    ) u_filter (
        .clk      (clk),
        .clr_     (clr_),
        .sync_in  (bus.sync_in),
        .filt_len (bus.filt_len),
        .lvl      (lvl),
        .commit   (commit),
        .rising   (rising)
    );

    always_comb begin
        evt_pulse_d = commit && edge_qualifies(edge_sel_e'(bus.edge_sel), rising);
    end

    // evt_pulse_q doubles as the internal event strobe; an event in the same
    // cycle as ack wins and restarts the status at one event.
    always_comb begin
        state_d = state_q;
        if (evt_pulse_q) begin
            state_d = (state_q == ST_IDLE || bus.ack) ? ST_PEND : ST_OVF;
        end else if (bus.ack) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (evt_pulse_q) begin
            if (bus.ack)               cnt_d = CNT_W'(1);
            else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else if (bus.ack) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            evt_pulse_q <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
        end else begin
            evt_pulse_q <= evt_pulse_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        bus.pending  = (state_q != ST_IDLE);
        bus.overflow = (state_q == ST_OVF);
    end

    assign bus.lvl_out   = lvl;
    assign bus.evt_pulse = evt_pulse_q;
    assign bus.evt_cnt   = cnt_q;

endmodule
